// File: rtl/k053252_cfg_loader_if.sv
// Host/CPU/CRTC signal bundle for the 053252 configuration loader.
// The master side drives the table and CPU ports; the slave side drives the CRTC bus.
interface k053252_cfg_loader_if;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned AB_W  = 4;
    localparam int unsigned DB_W  = 8;

    // host table port
    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_idx;
    logic [AB_W-1:0]   tbl_ab;
    logic [DB_W-1:0]   tbl_db;
    logic              tbl_valid;
    logic              start;

    // CPU passthrough port
    logic              cpu_ccs;
    logic              cpu_rw;
    logic [AB_W-1:0]   cpu_ab;
    logic [DB_W-1:0]   cpu_db;
    logic              cpu_wait;

    // CRTC bus and status
    logic              PIN_CCS;
    logic              PIN_RW;
    logic [AB_W-1:0]   PIN_AB;
    logic [DB_W-1:0]   PIN_DB_IN;
    logic              busy;
    logic              done;

    modport master (
        output tbl_we, tbl_idx, tbl_ab, tbl_db, tbl_valid, start,
        output cpu_ccs, cpu_rw, cpu_ab, cpu_db,
        input  cpu_wait, PIN_CCS, PIN_RW, PIN_AB, PIN_DB_IN, busy, done
    );

    modport slave (
        input  tbl_we, tbl_idx, tbl_ab, tbl_db, tbl_valid, start,
        input  cpu_ccs, cpu_rw, cpu_ab, cpu_db,
        output cpu_wait, PIN_CCS, PIN_RW, PIN_AB, PIN_DB_IN, busy, done
    );
endinterface

// File: rtl/k053252_cfg_loader.sv
// Replays a 16-entry {AB, DB, valid} table onto the 053252 CRTC register bus,
// sharing the bus with a CPU passthrough port while idle.
module k053252_cfg_loader #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                PIN_CLK,
    input  logic                PIN_RESET,
    k053252_cfg_loader_if.slave bus
);
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned AB_W    = 4;
    localparam int unsigned DB_W    = 8;
    localparam int unsigned N_ENT   = 16;
    localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_SETUP, S_CS, S_WR, S_RWH, S_HOLD, S_DONE
    } state_t;

    typedef struct packed {
        logic [AB_W-1:0] ab;
        logic [DB_W-1:0] db;
    } entry_t;

    entry_t             tbl_q [N_ENT];
    logic [N_ENT-1:0]   vld_q;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ccs_q, ccs_d;
    logic               rw_q, rw_d;
    logic [AB_W-1:0]    ab_q, ab_d;
    logic [DB_W-1:0]    db_q, db_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Table payload needs no reset; only the valid bits are cleared.
    always_ff @(posedge PIN_CLK) begin
        if (bus.tbl_we) begin
            tbl_q[bus.tbl_idx] <= {bus.tbl_ab, bus.tbl_db};
        end
    end

    always_ff @(posedge PIN_CLK) begin
        if (PIN_RESET) begin
            vld_q <= '0;
        end else if (bus.tbl_we) begin
            vld_q[bus.tbl_idx] <= bus.tbl_valid;
        end
    end

    // State, counters and registered bus outputs.
    always_ff @(posedge PIN_CLK) begin
        if (PIN_RESET) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ccs_q   <= 1'b1;
            rw_q    <= 1'b1;
            ab_q    <= '0;
            db_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ccs_q   <= ccs_d;
            rw_q    <= rw_d;
            ab_q    <= ab_d;
            db_q    <= db_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, then bus values for the state being entered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ccs_d   = 1'b1;
        rw_d    = 1'b1;
        ab_d    = ab_q;
        db_d    = db_q;

        case (state_q)
            S_IDLE: begin
                // A CPU access in the same cycle wins; the start is dropped.
                if (bus.start && bus.cpu_ccs) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (vld_q[idx_q]) begin
                    state_d = S_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    ab_d    = tbl_q[idx_q].ab;
                    db_d    = tbl_q[idx_q].db;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_CS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CS: begin
                state_d = S_WR;
                cnt_d   = CNT_W'(PULSE_CYC - 1);
            end
            S_WR: begin
                if (cnt_q == '0) begin
                    state_d = S_RWH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RWH: begin
                state_d = S_HOLD;
                cnt_d   = CNT_W'(HOLD_CYC - 1);
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SCAN;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // CPU passthrough only once the loader has fully returned to idle.
        case (state_d)
            S_IDLE: begin
                if (state_q == S_IDLE) begin
                    ccs_d = bus.cpu_ccs;
                    rw_d  = bus.cpu_rw;
                    ab_d  = bus.cpu_ab;
                    db_d  = bus.cpu_db;
                end
            end
            S_CS, S_RWH: begin
                ccs_d = 1'b0;
            end
            S_WR: begin
                ccs_d = 1'b0;
                rw_d  = 1'b0;
            end
            default: begin
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign bus.PIN_CCS   = ccs_q;
    assign bus.PIN_RW    = rw_q;
    assign bus.PIN_AB    = ab_q;
    assign bus.PIN_DB_IN = db_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cpu_wait  = busy_q & ~bus.cpu_ccs;

endmodule

// File: tb/tb_k053252_cfg_loader.sv
// Scoreboard bench for k053252_cfg_loader: expected CRTC writes are queued by the
// stimulus and popped by a bus monitor at the end of every CCS-low window.
module tb_k053252_cfg_loader;

    typedef struct packed {
        logic [3:0] ab;
        logic [7:0] db;
        logic       loader;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    bit   mon_en;
    int   rw_hi_viol;

    logic [3:0] std_ab [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA, 4'hB, 4'hC};
    logic [7:0] std_db [11] = '{8'h01, 8'h7F, 8'h00, 8'h11, 8'h00, 8'h27, 8'h01, 8'h07, 8'h10, 8'h0F, 8'h74};

    k053252_cfg_loader_if bus_if ();

    k053252_cfg_loader #(
        .SETUP_CYC (2),
        .PULSE_CYC (2),
        .HOLD_CYC  (1)
    ) dut (
        .PIN_CLK   (clk),
        .PIN_RESET (rst),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Bus monitor: one scoreboard pop per CCS-low window.
    logic [3:0] prev_ab, win_ab;
    logic [7:0] prev_db, win_db;
    int  stable, setup_len, ccs_len, rw_len;
    bit  in_win, win_unstable;
    initial begin
        prev_ab = '0; prev_db = '0; win_ab = '0; win_db = '0;
        stable = 0; setup_len = 0; ccs_len = 0; rw_len = 0;
        in_win = 0; win_unstable = 0;
    end

    always @(negedge clk) begin
        if (!mon_en || rst) begin
            in_win = 0;
            stable = 0;
        end else begin
            if (!bus_if.PIN_CCS) begin
                if (!in_win) begin
                    in_win       = 1;
                    setup_len    = stable;
                    win_ab       = bus_if.PIN_AB;
                    win_db       = bus_if.PIN_DB_IN;
                    ccs_len      = 0;
                    rw_len       = 0;
                    win_unstable = 0;
                end
                ccs_len++;
                if (!bus_if.PIN_RW) rw_len++;
                if (bus_if.PIN_AB != win_ab || bus_if.PIN_DB_IN != win_db) win_unstable = 1;
            end else begin
                if (!bus_if.PIN_RW) rw_hi_viol++;
                if (in_win) begin
                    exp_t e;
                    in_win = 0;
                    check("sb_nonempty", int'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("strobe_ab", int'(win_ab), int'(e.ab));
                        check("strobe_db", int'(win_db), int'(e.db));
                        check("ab_db_stable_in_window", int'(win_unstable), 0);
                        if (e.loader) begin
                            check("ccs_low_len", ccs_len, 4);
                            check("rw_low_len", rw_len, 2);
                            check("setup_stable_ge2", int'(setup_len >= 2), 1);
                        end
                    end
                end
            end
            if (bus_if.PIN_CCS) begin
                if (bus_if.PIN_AB == prev_ab && bus_if.PIN_DB_IN == prev_db) stable++;
                else stable = 1;
            end else begin
                stable = 0;
            end
            prev_ab = bus_if.PIN_AB;
            prev_db = bus_if.PIN_DB_IN;
        end
    end

    // All stimulus tasks start and end at posedge + 1.
    task automatic write_entry(input int idx, input logic [3:0] ab, input logic [7:0] db, input bit v);
        bus_if.tbl_we    = 1'b1;
        bus_if.tbl_idx   = 4'(idx);
        bus_if.tbl_ab    = ab;
        bus_if.tbl_db    = db;
        bus_if.tbl_valid = v;
        @(posedge clk); #1;
        bus_if.tbl_we    = 1'b0;
    endtask

    task automatic load_std_table();
        for (int i = 0; i < 16; i++) begin
            if (i < 11) write_entry(i, std_ab[i], std_db[i], 1'b1);
            else        write_entry(i, 4'h0, 8'h00, 1'b0);
        end
    endtask

    task automatic push_std_expected();
        for (int i = 0; i < 11; i++) sb.push_back({std_ab[i], std_db[i], 1'b1});
    endtask

    // Pulses start, then counts busy cycles; returns at the first negedge with busy low.
    task automatic run_replay(output int busy_cyc, output int done_cnt, output int done_last,
                              output int ccs_low);
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        busy_cyc = 0; done_cnt = 0; done_last = 0; ccs_low = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!bus_if.busy) break;
            busy_cyc++;
            done_last = bus_if.done ? 1 : 0;
            if (bus_if.done) done_cnt++;
            if (!bus_if.PIN_CCS) ccs_low++;
        end
    endtask

    int bc, dc, dl, cl, seen;

    initial begin
        n_tests = 0; n_fail = 0; rw_hi_viol = 0; mon_en = 1'b0;
        rst = 1'b1;
        bus_if.tbl_we = 0; bus_if.tbl_idx = 0; bus_if.tbl_ab = 0; bus_if.tbl_db = 0;
        bus_if.tbl_valid = 0; bus_if.start = 0;
        bus_if.cpu_ccs = 1; bus_if.cpu_rw = 1; bus_if.cpu_ab = 0; bus_if.cpu_db = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ccs", int'(bus_if.PIN_CCS), 1);
        check("rst_rw", int'(bus_if.PIN_RW), 1);
        check("rst_ab", int'(bus_if.PIN_AB), 0);
        check("rst_db", int'(bus_if.PIN_DB_IN), 0);
        check("rst_busy", int'(bus_if.busy), 0);
        check("rst_done", int'(bus_if.done), 0);
        check("rst_cpu_wait", int'(bus_if.cpu_wait), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Full replay of the 11-entry table
        load_std_table();
        push_std_expected();
        run_replay(bc, dc, dl, cl);
        check("replay_busy_cycles", bc, 94);
        check("replay_done_count", dc, 1);
        check("replay_done_on_last", dl, 1);
        repeat (3) @(posedge clk); #1;
        check("replay_sb_drained", sb.size(), 0);

        // Rewrite idx12 and the in-flight idx3 during replay
        load_std_table();
        push_std_expected();
        sb.push_back({4'h4, 8'h55, 1'b1});
        fork
            run_replay(bc, dc, dl, cl);
            begin
                repeat (26) @(posedge clk); #1;
                write_entry(12, 4'h4, 8'h55, 1'b1);
                write_entry(3, 4'hD, 8'hEE, 1'b1);
            end
        join
        check("rewrite_busy_cycles", bc, 101);
        check("rewrite_done_count", dc, 1);
        repeat (3) @(posedge clk); #1;
        check("rewrite_sb_drained", sb.size(), 0);

        // CPU write held off during replay, then passed through once idle
        load_std_table();
        push_std_expected();
        fork
            run_replay(bc, dc, dl, cl);
            begin
                repeat (10) @(posedge clk); #1;
                sb.push_back({4'h5, 8'h3A, 1'b0});
                bus_if.cpu_ccs = 0; bus_if.cpu_rw = 0; bus_if.cpu_ab = 4'h5; bus_if.cpu_db = 8'h3A;
                @(negedge clk);
                check("cpu_wait_during_replay", int'(bus_if.cpu_wait), 1);
            end
        join
        check("arb_busy_cycles", bc, 94);
        check("arb_idle_ccs_not_yet_cpu", int'(bus_if.PIN_CCS), 1);
        check("arb_cpu_wait_released", int'(bus_if.cpu_wait), 0);
        @(negedge clk);
        check("arb_cpu_ab", int'(bus_if.PIN_AB), 5);
        check("arb_cpu_db", int'(bus_if.PIN_DB_IN), 8'h3A);
        check("arb_cpu_ccs", int'(bus_if.PIN_CCS), 0);
        @(posedge clk); #1;
        bus_if.cpu_ccs = 1; bus_if.cpu_rw = 1; bus_if.cpu_ab = 0; bus_if.cpu_db = 0;
        repeat (3) @(posedge clk); #1;
        check("arb_sb_drained", sb.size(), 0);

        // Start coincident with a CPU access is dropped
        sb.push_back({4'h7, 8'h42, 1'b0});
        bus_if.cpu_ccs = 0; bus_if.cpu_rw = 0; bus_if.cpu_ab = 4'h7; bus_if.cpu_db = 8'h42;
        run_replay(bc, dc, dl, cl);
        @(posedge clk); #1;
        bus_if.cpu_ccs = 1; bus_if.cpu_rw = 1; bus_if.cpu_ab = 0; bus_if.cpu_db = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_if.busy) bc++;
        end
        check("coincident_start_busy", bc, 0);
        @(posedge clk); #1;
        check("coincident_sb_drained", sb.size(), 0);

        // Reset while RW is low: bus idles next cycle, no done
        mon_en = 1'b0;
        load_std_table();
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus_if.PIN_RW) begin
                seen = 1;
                break;
            end
        end
        check("reset_reached_wr", seen, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ccs", int'(bus_if.PIN_CCS), 1);
        check("midrst_rw", int'(bus_if.PIN_RW), 1);
        check("midrst_busy", int'(bus_if.busy), 0);
        dc = 0; cl = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus_if.done) dc++;
            if (!bus_if.PIN_CCS) cl++;
            @(negedge clk);
        end
        check("midrst_no_done", dc, 0);
        check("midrst_no_strobe", cl, 0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Reset cleared every valid bit: empty-table replay
        run_replay(bc, dc, dl, cl);
        check("empty_busy_cycles", bc, 17);
        check("empty_done_count", dc, 1);
        check("empty_ccs_low_cycles", cl, 0);
        repeat (3) @(posedge clk); #1;

        check("rw_low_with_ccs_high", rw_hi_viol, 0);
        check("final_sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/k053252_cfg_loader.md
Name: k053252_cfg_loader

Overview:
- Boot-time and mode-change configurator for the 053252 CRTC register bus (CCS/RW/AB/DB).
- Holds a 16-entry table of {register address, data, valid} written by the host.
- On start, replays the valid entries to the CRTC in index order using the chip's write sequence: drive AB/DB, drop CCS, pulse RW low, raise RW, raise CCS.
- Arbitrates the CRTC bus with a CPU passthrough port so game code can still poke registers while the loader is idle.

Parameters:
SETUP_CYC, 2, cycles AB/DB are stable with CCS=1 before the strobe (>=1)
PULSE_CYC, 2, cycles RW is held low (>=1)
HOLD_CYC, 1, cycles CCS=1 with AB/DB held after the strobe (>=1)

Ports:
PIN_CLK  in  1  system clock, all logic on rising edge
PIN_RESET  in  1  synchronous reset, active-high
tbl_we  in  1  table write strobe
tbl_idx  in  4  table entry index
tbl_ab  in  4  CRTC register address for the entry
tbl_db  in  8  data for the entry
tbl_valid  in  1  entry valid flag
start  in  1  single-cycle request to replay the table
cpu_ccs  in  1  CPU chip select, active-low
cpu_rw  in  1  CPU read/write (0 = write)
cpu_ab  in  4  CPU address
cpu_db  in  8  CPU write data
cpu_wait  out  1  CPU access stalled; high while cpu_ccs=0 and the loader owns the bus
PIN_CCS  out  1  to CRTC
PIN_RW  out  1  to CRTC
PIN_AB  out  4  to CRTC
PIN_DB_IN  out  8  to CRTC data input
busy  out  1  high whenever state != IDLE
done  out  1  single-cycle pulse when the replay completes

Behaviour:
- Reset:
  - State IDLE, idx=0, all valid bits cleared (table data bits are don't-care).
  - Registered bus outputs PIN_CCS=1, PIN_RW=1, PIN_AB=0, PIN_DB_IN=0.
  - busy=0, done=0, cpu_wait=0.
  - Reset mid-sequence aborts on the next edge; the bus returns to idle with no further strobes and no done pulse.
- Table write: on tbl_we, entry[tbl_idx] <= {tbl_ab, tbl_db, tbl_valid}.
  - Writes are accepted in any state.
  - A write to an entry not yet reached is used by the replay. A write to the entry currently being sent does not affect the latched bus values.
- Bus ownership:
  - In IDLE, the outputs register the CPU port: PIN_CCS<=cpu_ccs, PIN_RW<=cpu_rw, PIN_AB<=cpu_ab, PIN_DB_IN<=cpu_db. Latency is 1 cycle.
  - In all other states the loader drives the bus, and cpu_wait = ~cpu_ccs.
- Start:
  - start is sampled only in IDLE and ignored elsewhere (no queueing).
  - If start=1 and cpu_ccs=0 on the same cycle, the CPU wins. start is dropped, not deferred, and the caller must retry.
- FSM states, with bus values driven in each state (counters reload on entry):
  - IDLE: start & cpu_ccs -> SCAN with idx=0.
  - SCAN (1 cycle per index, CCS=1, RW=1):
    - entry[idx].valid -> SETUP, latching AB/DB from the entry.
    - Otherwise, idx==15 -> DONE, else idx+1 and stay in SCAN.
  - SETUP (SETUP_CYC cycles, CCS=1, RW=1, AB/DB driven) -> CS.
  - CS (1 cycle, CCS=0, RW=1) -> WR.
  - WR (PULSE_CYC cycles, CCS=0, RW=0) -> RWH.
  - RWH (1 cycle, CCS=0, RW=1) -> HOLD.
  - HOLD (HOLD_CYC cycles, CCS=1, RW=1, AB/DB held): idx==15 -> DONE, else idx+1 -> SCAN.
  - DONE (1 cycle, done=1, busy=1) -> IDLE.
- Cycle cost:
  - Each valid entry costs 1 (SCAN) + SETUP_CYC + 1 + PULSE_CYC + 1 + HOLD_CYC cycles, which is 8 at defaults.
  - Each invalid entry costs 1 cycle.
  - With defaults: total busy cycles = 16 + 7·Nvalid + 1.
- An all-invalid table runs 16 SCAN cycles + DONE with PIN_CCS held at 1, so there are no strobes.
- idx wraps never; the sequence ends at index 15.
- AB/DB change only on the SCAN->SETUP transition, so they are stable across the whole CCS=0 window.
- RW never goes low while CCS=1 during loader operation.

Test Plan:
- Reset mid-WR (PIN_RW=0) -> next cycle PIN_CCS=1, PIN_RW=1, busy=0, no done pulse.
- Table load, then replay: load idx0..10 = (0,01),(1,7F),(2,00),(3,11),(4,00),(5,27),(6,01),(9,07),(A,10),(B,0F),(C,74) with idx11..15 invalid, pulse start.
  - Required: exactly 11 RW-low windows, each 2 cycles, in that order with matching AB/DB.
  - busy high for 94 cycles, done pulse on the 94th.
- Strobe shape per entry:
  - AB/DB stable 2 cycles before CCS falls.
  - CCS low 4 cycles, RW low for the middle 2.
  - CCS high 1 cycle after the strobe before the next SCAN.
- CPU arbitration:
  - CPU write (AB=5, DB=3A) during replay -> cpu_wait=1 and no bus change until DONE. Hold cpu_ccs low; once in IDLE, PIN_AB=5 and PIN_DB_IN=3A appear 1 cycle later.
  - start coincident with cpu_ccs=0 -> busy stays 0.
- Empty table + start -> busy for 17 cycles, done once, PIN_CCS stays 1 throughout.
- Table rewrite during replay: write idx12=(4,55,valid) while the loader is at idx3 -> a 12th strobe with AB=4, DB=55 occurs.
  - Writing the entry currently in SETUP leaves that strobe's AB/DB unchanged.
